// File: rtl/vend_ctrl_pkg.sv
// Shared coin codes, coin values and sequencer state encodings for the vending controller.
package vend_ctrl_pkg;

   typedef enum logic [1:0] {
      COIN_5C   = 2'b00,
      COIN_10C  = 2'b01,
      COIN_25C  = 2'b10,
      COIN_100C = 2'b11
   } coin_sel_e;

   localparam logic [7:0] VAL_5C   = 8'd5;
   localparam logic [7:0] VAL_10C  = 8'd10;
   localparam logic [7:0] VAL_25C  = 8'd25;
   localparam logic [7:0] VAL_100C = 8'd100;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_VEND   = 2'd1,
      ST_CHANGE = 2'd2
   } state_e;

endpackage

// File: rtl/vend_ctrl_coin_value_lut.sv
// Combinational coin code to cent value lookup; zero latency, no flow control.
module vend_ctrl_coin_value_lut
   import vend_ctrl_pkg::*;
(
   input  logic [1:0] coin_sel_i,
   output logic [7:0] value_o
);

   always_comb begin
      value_o = VAL_5C;
      case (coin_sel_e'(coin_sel_i))
         COIN_5C:   value_o = VAL_5C;
         COIN_10C:  value_o = VAL_10C;
         COIN_25C:  value_o = VAL_25C;
         COIN_100C: value_o = VAL_100C;
      endcase
   end

endmodule

// File: rtl/vend_ctrl.sv
// Coin credit accumulator with vend and largest-first change sequencer; registered outputs, 1-cycle latency.
// No backpressure: strobes are never stalled, coins that cannot be taken are answered with a reject pulse.
module vend_ctrl
   import vend_ctrl_pkg::*;
#(
   parameter int unsigned PRICE      = 65,
   parameter int unsigned MAX_CREDIT = 200
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_valid_i,
   input  logic [1:0] coin_sel_i,
   input  logic       buy_i,
   input  logic       cancel_i,
   output logic [7:0] credit_o,
   output logic       coin_reject_o,
   output logic       vend_o,
   output logic       chg_valid_o,
   output logic [1:0] chg_sel_o,
   output logic       busy_o
);

   localparam logic [8:0] PRICE9 = 9'(PRICE);
   localparam logic [7:0] PRICE8 = 8'(PRICE);
   localparam logic [8:0] MAX9   = 9'(MAX_CREDIT);
   localparam bit CFG_OK = (PRICE % 5 == 0) && (PRICE != 0) &&
                           (PRICE <= MAX_CREDIT) && (MAX_CREDIT <= 255);

   state_e     state_q, state_d;
   logic [7:0] credit_q, credit_d;
   logic       reject_q, reject_d;
   logic       vend_q, vend_d;
   logic       chg_valid_q, chg_valid_d;
   logic [1:0] chg_sel_q, chg_sel_d;

   logic [7:0] coin_val;
   logic [8:0] credit9;
   logic [8:0] coin_sum;
   coin_sel_e  pick_sel;
   logic [7:0] pick_val;
   logic       enter_change;

   vend_ctrl_coin_value_lut u_coin_lut (
      .coin_sel_i (coin_sel_i),
      .value_o    (coin_val)
   );

   assign credit9  = {1'b0, credit_q};
   assign coin_sum = credit9 + {1'b0, coin_val};

   // Change is paid largest-first from 25/10/5 only; credit stays a multiple of 5.
   always_comb begin
      pick_sel = COIN_5C;
      pick_val = VAL_5C;
      if (credit9 >= {1'b0, VAL_25C}) begin
         pick_sel = COIN_25C;
         pick_val = VAL_25C;
      end else if (credit9 >= {1'b0, VAL_10C}) begin
         pick_sel = COIN_10C;
         pick_val = VAL_10C;
      end
   end

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      reject_d     = 1'b0;
      vend_d       = 1'b0;
      chg_valid_d  = 1'b0;
      chg_sel_d    = 2'b00;
      enter_change = 1'b0;
      case (state_q)
         ST_ACCEPT: begin
            if (cancel_i) begin
               enter_change = (credit_q != 8'd0);
            end else if (buy_i) begin
               if (credit9 >= PRICE9) begin
                  state_d  = ST_VEND;
                  vend_d   = 1'b1;
                  credit_d = credit_q - PRICE8;
               end
            end else if (coin_valid_i) begin
               if (coin_sum <= MAX9) credit_d = coin_sum[7:0];
               else                  reject_d = 1'b1;
            end
            // Any BUY/CANCEL strobe consumes the coin slot, taken or not.
            if (coin_valid_i && (cancel_i || buy_i)) reject_d = 1'b1;
         end
         ST_VEND, ST_CHANGE: begin
            if (credit_q != 8'd0) enter_change = 1'b1;
            else                  state_d      = ST_ACCEPT;
            reject_d = coin_valid_i;
         end
         default: state_d = ST_ACCEPT;
      endcase
      if (enter_change) begin
         state_d     = ST_CHANGE;
         chg_valid_d = 1'b1;
         chg_sel_d   = pick_sel;
         credit_d    = credit_q - pick_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACCEPT;
         credit_q    <= 8'd0;
         reject_q    <= 1'b0;
         vend_q      <= 1'b0;
         chg_valid_q <= 1'b0;
         chg_sel_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         reject_q    <= reject_d;
         vend_q      <= vend_d;
         chg_valid_q <= chg_valid_d;
         chg_sel_q   <= chg_sel_d;
      end
   end

   assign credit_o      = credit_q;
   assign coin_reject_o = reject_q;
   assign vend_o        = vend_q;
   assign chg_valid_o   = chg_valid_q;
   assign chg_sel_o     = chg_sel_q;
   assign busy_o        = (state_q != ST_ACCEPT);

   a_cfg_ok: assert property (@(posedge clk) CFG_OK);
   a_credit_mult5: assert property (@(posedge clk) disable iff (!rst_n)
                                    (credit_q % 8'd5) == 8'd0);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed scoreboard bench for vend_ctrl with PRICE=65, MAX_CREDIT=200.
module tb_vend_ctrl;

   localparam logic [1:0] C5 = 2'b00, C10 = 2'b01, C25 = 2'b10, C100 = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       coin_valid_i = 1'b0;
   logic [1:0] coin_sel_i = 2'b00;
   logic       buy_i = 1'b0;
   logic       cancel_i = 1'b0;
   logic [7:0] credit_o;
   logic       coin_reject_o, vend_o, chg_valid_o, busy_o;
   logic [1:0] chg_sel_o;
   bit         mark = 1'b0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit         mark;
      bit         vend;
      bit         rej;
      bit         chg;
      logic [1:0] sel;
      logic [7:0] credit;
      bit         busy;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   vend_ctrl #(.PRICE(65), .MAX_CREDIT(200)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .coin_valid_i  (coin_valid_i),
      .coin_sel_i    (coin_sel_i),
      .buy_i         (buy_i),
      .cancel_i      (cancel_i),
      .credit_o      (credit_o),
      .coin_reject_o (coin_reject_o),
      .vend_o        (vend_o),
      .chg_valid_o   (chg_valid_o),
      .chg_sel_o     (chg_sel_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   task automatic push(bit mk, bit v, bit r, bit c, logic [1:0] s,
                       logic [7:0] cr, bit b, string n);
      exp_t x;
      x.mark = mk; x.vend = v; x.rej = r; x.chg = c;
      x.sel = s; x.credit = cr; x.busy = b; x.name = n;
      sb.push_back(x);
   endtask

   task automatic drive(bit cv, logic [1:0] sel, bit b, bit c);
      @(posedge clk);
      #2;
      coin_valid_i = cv; coin_sel_i = sel; buy_i = b; cancel_i = c; mark = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 1'b0);
   endtask

   // Quiet-cycle probe: credit and busy as seen after the previous edge.
   task automatic markchk(logic [7:0] cr, bit b, string n);
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      push(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, cr, b, n);
      mark = 1'b1;
   endtask

   task automatic chk(string n, logic [7:0] got, logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", n, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (vend_o || coin_reject_o || chg_valid_o) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pulse: got vend=%0b rej=%0b chg=%0b sel=%0d credit=%0d, expected no pulse at %0t",
                        vend_o, coin_reject_o, chg_valid_o, chg_sel_o, credit_o, $time);
            end else begin
               e = sb.pop_front();
               if (e.mark || vend_o !== e.vend || coin_reject_o !== e.rej || chg_valid_o !== e.chg ||
                   chg_sel_o !== e.sel || credit_o !== e.credit || busy_o !== e.busy) begin
                  failures++;
                  $display("FAIL %s: got vend=%0b rej=%0b chg=%0b sel=%0d credit=%0d busy=%0b, expected mark=%0b vend=%0b rej=%0b chg=%0b sel=%0d credit=%0d busy=%0b",
                           e.name, vend_o, coin_reject_o, chg_valid_o, chg_sel_o, credit_o, busy_o,
                           e.mark, e.vend, e.rej, e.chg, e.sel, e.credit, e.busy);
               end
            end
         end
         if (mark) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL probe_underflow: got credit=%0d busy=%0b, expected a queued probe", credit_o, busy_o);
            end else begin
               e = sb.pop_front();
               if (!e.mark || credit_o !== e.credit || busy_o !== e.busy || chg_sel_o !== 2'b00) begin
                  failures++;
                  $display("FAIL %s: got credit=%0d busy=%0b chg_sel=%0d, expected mark=%0b credit=%0d busy=%0b chg_sel=0",
                           e.name, credit_o, busy_o, chg_sel_o, e.mark, e.credit, e.busy);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got no end of stimulus, expected finish before 100000");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1 rst_n = 1'b0;
      #3;
      chk("rst_credit", credit_o, 8'd0);
      chk("rst_vend", 8'(vend_o), 8'd0);
      chk("rst_reject", 8'(coin_reject_o), 8'd0);
      chk("rst_chg_valid", 8'(chg_valid_o), 8'd0);
      chk("rst_chg_sel", 8'(chg_sel_o), 8'd0);
      chk("rst_busy", 8'(busy_o), 8'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // 25+25+25 then BUY: vend leaves 10, paid as one 10c coin
      drive(1'b1, C25, 1'b0, 1'b0); markchk(8'd25, 1'b0, "t2_credit25");
      drive(1'b1, C25, 1'b0, 1'b0); markchk(8'd50, 1'b0, "t2_credit50");
      drive(1'b1, C25, 1'b0, 1'b0); markchk(8'd75, 1'b0, "t2_credit75");
      push(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd10, 1'b1, "t2_vend");
      push(1'b0, 1'b0, 1'b0, 1'b1, C10,   8'd0,  1'b1, "t2_chg10");
      drive(1'b0, C5, 1'b1, 1'b0);
      idle(2);
      markchk(8'd0, 1'b0, "t2_idle");

      // Ceiling: 100+100 fits exactly, next 5c is rejected
      drive(1'b1, C100, 1'b0, 1'b0); markchk(8'd100, 1'b0, "t3_credit100");
      drive(1'b1, C100, 1'b0, 1'b0); markchk(8'd200, 1'b0, "t3_credit200");
      push(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd200, 1'b0, "t3_reject5");
      drive(1'b1, C5, 1'b0, 1'b0);
      idle(1);
      markchk(8'd200, 1'b0, "t3_credit_held");

      // BUY from 200: 135 change as 25x5 then 10, back-to-back
      push(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd135, 1'b1, "t5_vend");
      push(1'b0, 1'b0, 1'b0, 1'b1, C25, 8'd110, 1'b1, "t5_chg1");
      push(1'b0, 1'b0, 1'b0, 1'b1, C25, 8'd85,  1'b1, "t5_chg2");
      push(1'b0, 1'b0, 1'b0, 1'b1, C25, 8'd60,  1'b1, "t5_chg3");
      push(1'b0, 1'b0, 1'b0, 1'b1, C25, 8'd35,  1'b1, "t5_chg4");
      push(1'b0, 1'b0, 1'b0, 1'b1, C25, 8'd10,  1'b1, "t5_chg5");
      push(1'b0, 1'b0, 1'b0, 1'b1, C10, 8'd0,   1'b1, "t5_chg6");
      drive(1'b0, C5, 1'b1, 1'b0);
      idle(7);
      markchk(8'd0, 1'b0, "t5_idle");

      // Short BUY is ignored, CANCEL returns 10
      drive(1'b1, C10, 1'b0, 1'b0); markchk(8'd10, 1'b0, "t4_credit10");
      drive(1'b0, C5, 1'b1, 1'b0);  markchk(8'd10, 1'b0, "t4_buy_ignored");
      push(1'b0, 1'b0, 1'b0, 1'b1, C10, 8'd0, 1'b1, "t4_cancel_chg10");
      drive(1'b0, C5, 1'b0, 1'b1);
      idle(1);
      markchk(8'd0, 1'b0, "t4_idle");
      drive(1'b0, C5, 1'b0, 1'b1);  markchk(8'd0, 1'b0, "t4_cancel_noop");

      // Coin during CHANGE is rejected, change stream unaffected
      drive(1'b1, C25, 1'b0, 1'b0); markchk(8'd25, 1'b0, "t6_credit25");
      drive(1'b1, C10, 1'b0, 1'b0); markchk(8'd35, 1'b0, "t6_credit35");
      push(1'b0, 1'b0, 1'b0, 1'b1, C25, 8'd10, 1'b1, "t6_chg25");
      push(1'b0, 1'b0, 1'b1, 1'b1, C10, 8'd0,  1'b1, "t6_chg10_rej");
      drive(1'b0, C5, 1'b0, 1'b1);
      drive(1'b1, C100, 1'b0, 1'b0);
      idle(1);
      markchk(8'd0, 1'b0, "t6_idle");

      // Coin with a taken BUY: vend plus reject, then 35 as 25+10
      drive(1'b1, C100, 1'b0, 1'b0); markchk(8'd100, 1'b0, "t6_credit100");
      push(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'd35, 1'b1, "t6_vend_rej");
      push(1'b0, 1'b0, 1'b0, 1'b1, C25, 8'd10, 1'b1, "t6_buy_chg25");
      push(1'b0, 1'b0, 1'b0, 1'b1, C10, 8'd0,  1'b1, "t6_buy_chg10");
      drive(1'b1, C5, 1'b1, 1'b0);
      idle(3);
      markchk(8'd0, 1'b0, "t6_buy_idle");

      // Coin with an ignored BUY is still rejected
      push(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0, "coin_with_short_buy");
      drive(1'b1, C10, 1'b1, 1'b0);
      idle(1);
      markchk(8'd0, 1'b0, "short_buy_idle");

      // Async reset mid-CHANGE with 35 left
      drive(1'b1, C25, 1'b0, 1'b0); markchk(8'd25, 1'b0, "t1_credit25");
      drive(1'b1, C25, 1'b0, 1'b0); markchk(8'd50, 1'b0, "t1_credit50");
      drive(1'b1, C10, 1'b0, 1'b0); markchk(8'd60, 1'b0, "t1_credit60");
      push(1'b0, 1'b0, 1'b0, 1'b1, C25, 8'd35, 1'b1, "t1_chg25");
      drive(1'b0, C5, 1'b0, 1'b1);
      @(posedge clk);
      #7;
      rst_n = 1'b0;
      cancel_i = 1'b0;
      #1;
      chk("t1_rst_credit", credit_o, 8'd0);
      chk("t1_rst_chg_valid", 8'(chg_valid_o), 8'd0);
      chk("t1_rst_busy", 8'(busy_o), 8'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      idle(4);
      markchk(8'd0, 1'b0, "t1_after_release");
      idle(2);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
